mat_stream_reader: RTL and testbench



---
 rtl/mat_stream_reader.sv | 200 ++++++++++++++++++++
 tb/tb_mat_stream_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_stream_reader.sv
// mat_stream_reader
//   Read-side controller for the matrix block RAM (m*n words, 2*DW bits each,
//   1-cycle registered read). On an accepted start it walks every element,
//   in row-major order or transposed (column-major), and streams the returned
//   words on a valid/ready interface. A 2-entry output FIFO with credit-based
//   issue absorbs backpressure without losing or duplicating words.
//
// Optional feature: define MAT_STREAM_COORD_EN to add out_row/out_col, which
//   carry each word's (r,c) through the FIFO alongside the data.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, transpose  run request (IDLE only) and order select latched with it
//   busy, done        run in progress / one-cycle completion pulse
//   mem_*             RAM read port (mem_writeEN tied low)
//   out_valid/ready   output stream handshake
//   out_data/last     stream word and final-element marker
//   out_row/out_col   element coordinates (MAT_STREAM_COORD_EN only)
module mat_stream_reader #(
  parameter int DW = 8,
  parameter int m  = 8,
  parameter int n  = 8,
  localparam int RW = (m > 1) ? $clog2(m) : 1,
  localparam int CW = (n > 1) ? $clog2(n) : 1,
  localparam int AW = m + n
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            transpose,
  output logic            busy,
  output logic            done,
  output logic            mem_ramEN,
  output logic            mem_readEN,
  output logic            mem_writeEN,
  output logic [AW-1:0]   mem_addr,
  input  logic [2*DW-1:0] mem_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_data,
  output logic            out_last
`ifdef MAT_STREAM_COORD_EN
  ,
  output logic [RW-1:0]   out_row,
  output logic [CW-1:0]   out_col
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state;
  logic            order_q;   // 1 = column-major walk
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q;
  logic            row_end, col_end, last_elem;

  logic            inflight;  // a read issued last cycle returns data now
  logic            infl_last;
  logic [2*DW-1:0] fifo_data [2];
  logic [1:0]      fifo_last;
  logic            head, tail;
  logic [1:0]      fifo_count;
  logic [2:0]      committed;
  logic            pop, issue;

`ifdef MAT_STREAM_COORD_EN
  logic [RW-1:0]   infl_row;
  logic [CW-1:0]   infl_col;
  logic [RW-1:0]   fifo_row [2];
  logic [CW-1:0]   fifo_col [2];
`endif

  assign row_end   = (row_q == RW'(m - 1));
  assign col_end   = (col_q == CW'(n - 1));
  // The final element is (m-1,n-1) in both walk orders.
  assign last_elem = row_end && col_end;

  assign pop       = out_valid && out_ready;
  // Words already owed to the FIFO after this cycle's pop; issuing only while
  // this is below 2 means a returning word always has a slot.
  assign committed = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  // NOTE: issue depends combinationally on out_ready so a pop frees a slot in
  // the same cycle; this is what keeps full throughput with ready held high.
  assign issue     = (state == S_RUN) && (committed < 3'd2);

  assign mem_ramEN   = issue;
  assign mem_readEN  = issue;
  assign mem_writeEN = 1'b0;
  assign mem_addr    = AW'(row_q) * AW'(n) + AW'(col_q);

  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_data[head];
  assign out_last  = fifo_last[head];
`ifdef MAT_STREAM_COORD_EN
  assign out_row   = fifo_row[head];
  assign out_col   = fifo_col[head];
`endif

  // Control FSM and element counters.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      order_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            order_q <= transpose;
            row_q   <= '0;
            col_q   <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            // Inner index advances every issue; outer index on inner wrap.
            // Both wrap to 0 after the final element.
            if (!order_q) begin
              if (col_end) begin
                col_q <= '0;
                row_q <= row_end ? '0 : row_q + RW'(1);
              end else begin
                col_q <= col_q + CW'(1);
              end
            end else begin
              if (row_end) begin
                row_q <= '0;
                col_q <= col_end ? '0 : col_q + CW'(1);
              end else begin
                row_q <= row_q + RW'(1);
              end
            end
            if (last_elem) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && out_last) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-return capture and 2-entry output FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= 1'b0;
      infl_last  <= 1'b0;
      head       <= 1'b0;
      tail       <= 1'b0;
      fifo_count <= 2'd0;
      fifo_last  <= 2'b00;
      // NOTE: the two storage entries are reset because out_data is read
      // straight from them and must show 0 out of reset.
      for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
`ifdef MAT_STREAM_COORD_EN
      infl_row <= '0;
      infl_col <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_row[i] <= '0;
        fifo_col[i] <= '0;
      end
`endif
    end else begin
      inflight  <= issue;
      infl_last <= last_elem;
`ifdef MAT_STREAM_COORD_EN
      infl_row <= row_q;
      infl_col <= col_q;
`endif
      if (inflight) begin
        fifo_data[tail] <= mem_data;
        fifo_last[tail] <= infl_last;
`ifdef MAT_STREAM_COORD_EN
        fifo_row[tail] <= infl_row;
        fifo_col[tail] <= infl_col;
`endif
        tail <= ~tail;
      end
      if (pop) head <= ~head;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_mat_stream_reader.sv
// Self-checking bench for mat_stream_reader (m=2, n=3, DW=8). A behavioural
// model tracks how many words have been issued and consumed per run and the
// cycle each was issued, and derives every expected output from the element
// order, the credit limit and the 2-cycle read latency. Directed literal
// scenarios pin the model; randomized runs stress backpressure and reset.
module tb_mat_stream_reader;
  localparam int DW = 8;
  localparam int M = 2;
  localparam int N = 3;
  localparam int AW = M + N;
  localparam int TOTAL = M * N;

  logic clk = 1'b0;
  logic rst, start, transpose, out_ready;
  logic busy, done, mem_ramEN, mem_readEN, mem_writeEN;
  logic [AW-1:0] mem_addr;
  logic [2*DW-1:0] mem_data, out_data;
  logic out_valid, out_last;
`ifdef MAT_STREAM_COORD_EN
  logic [0:0] out_row;
  logic [1:0] out_col;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_count = 0;
  int done_pulses = 0;
  logic [15:0] ram [0:(1<<AW)-1];

  always #5 clk = ~clk;

  mat_stream_reader #(.DW(DW), .m(M), .n(N)) dut (
    .clk(clk), .rst(rst), .start(start), .transpose(transpose),
    .busy(busy), .done(done),
    .mem_ramEN(mem_ramEN), .mem_readEN(mem_readEN), .mem_writeEN(mem_writeEN),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
`ifdef MAT_STREAM_COORD_EN
    , .out_row(out_row), .out_col(out_col)
`endif
  );

  // RAM model: 1-cycle registered read.
  always @(posedge clk) if (mem_ramEN) mem_data <= ram[mem_addr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Element order from the matrix walk rules.
  function automatic int elem_row(input bit tr, input int i);
    return tr ? (i % M) : (i / N);
  endfunction
  function automatic int elem_col(input bit tr, input int i);
    return tr ? (i / M) : (i % N);
  endfunction
  function automatic int elem_addr(input bit tr, input int i);
    return elem_row(tr, i) * N + elem_col(tr, i);
  endfunction

  // ---------------- behavioural model + compare process ----------------
  typedef enum {P_IDLE, P_ACTIVE, P_DONE} phase_t;
  phase_t ph = P_IDLE;
  bit   mon_en = 1'b0;
  bit   m_tr = 1'b0;
  int   issued = 0;
  int   popped = 0;
  int   issue_cyc [TOTAL];
  logic exp_busy = 1'b0;
  logic exp_done = 1'b0;
  logic m_valid, m_pop, m_issue;

  always @(negedge clk) begin
    cyc++;
    if (out_valid === 1'b1 && out_ready === 1'b1) hs_count++;
    if (done === 1'b1) done_pulses++;
    if (mon_en) begin
      m_valid = (popped < issued) && (issue_cyc[popped] + 2 <= cyc);
      m_pop   = m_valid && out_ready;
      m_issue = (ph == P_ACTIVE) && (issued < TOTAL) &&
                ((issued - popped - (m_pop ? 1 : 0)) < 2);

      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("readEN_eq_ramEN", 32'(mem_readEN), 32'(mem_ramEN));
      check("writeEN", 32'(mem_writeEN), 32'd0);
      check("ramEN", 32'(mem_ramEN), 32'(m_issue));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_issue) check("mem_addr", 32'(mem_addr), 32'(elem_addr(m_tr, issued)));
      if (m_valid) begin
        check("out_data", 32'(out_data), 32'(16'hA000 + 16'(elem_addr(m_tr, popped))));
        check("out_last", 32'(out_last), 32'(popped == TOTAL - 1));
`ifdef MAT_STREAM_COORD_EN
        check("out_row", 32'(out_row), 32'(elem_row(m_tr, popped)));
        check("out_col", 32'(out_col), 32'(elem_col(m_tr, popped)));
`endif
      end

      if (rst) begin
        ph = P_IDLE; issued = 0; popped = 0; exp_busy = 1'b0; exp_done = 1'b0;
      end else begin
        exp_done = 1'b0;
        case (ph)
          P_IDLE: if (start) begin
            ph = P_ACTIVE; m_tr = transpose; issued = 0; popped = 0; exp_busy = 1'b1;
          end
          P_ACTIVE: begin
            if (m_pop && popped == TOTAL - 1) begin ph = P_DONE; exp_done = 1'b1; end
            if (m_pop) popped++;
            if (m_issue) begin issue_cyc[issued] = cyc; issued++; end
          end
          P_DONE: begin ph = P_IDLE; exp_busy = 1'b0; end
          default: ph = P_IDLE;
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start in cycle 0 with out_ready=1 and check literal cycle-exact results.
  task automatic run_literal(input bit tr);
    int ord [6];
    if (tr) ord = '{0, 3, 1, 4, 2, 5};
    else    ord = '{0, 1, 2, 3, 4, 5};
    out_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      start = (c == 0);
      transpose = tr;
      @(negedge clk);
      if (c >= 1 && c <= 6) begin
        check("lit_ramEN", 32'(mem_ramEN), 32'd1);
        check("lit_addr", 32'(mem_addr), 32'(ord[c-1]));
      end
      if (c >= 3 && c <= 8) begin
        check("lit_valid", 32'(out_valid), 32'd1);
        check("lit_data", 32'(out_data), 32'(16'hA000 + 16'(ord[c-3])));
        check("lit_last", 32'(out_last), 32'(c == 8));
`ifdef MAT_STREAM_COORD_EN
        if (!tr) begin
          check("lit_row", 32'(out_row), 32'((c - 3) / 3));
          check("lit_col", 32'(out_col), 32'((c - 3) % 3));
        end
`endif
      end
      if (c == 9) begin
        check("lit_done", 32'(done), 32'd1);
        check("lit_busy_done", 32'(busy), 32'd1);
      end
      if (c == 10) check("lit_busy_end", 32'(busy), 32'd0);
      step();
    end
  endtask

  // Start a run and let it finish under random stimulus; rst_at < 0 = no reset.
  task automatic run_stream(input bit tr, input int ready_pct, input int start_pct,
                            input int rst_at, input int budget);
    bit ended = 1'b0;
    start = 1'b1; transpose = tr; out_ready = 1'b1; rst = 1'b0;
    step();
    start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      if (ph == P_IDLE) begin ended = 1'b1; break; end
      out_ready = ($urandom_range(99) < ready_pct);
      start     = ($urandom_range(99) < start_pct);
      transpose = 1'($urandom_range(1));
      rst       = (k == rst_at);
      step();
    end
    start = 1'b0; rst = 1'b0; out_ready = 1'b1;
    if (!ended && ph != P_IDLE) check("run_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int base_h, base_d, stall;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 16'hA000 + 16'(i);
    rst = 1'b1; start = 1'b0; transpose = 1'b0; out_ready = 1'b1;
    step();
    step();
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ramEN", 32'(mem_ramEN), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
`ifdef MAT_STREAM_COORD_EN
    check("rst_row", 32'(out_row), 32'd0);
    check("rst_col", 32'(out_col), 32'd0);
`endif
    step();
    rst = 1'b0;
    step();

    // Row-major and transposed, full throughput.
    run_literal(1'b0);
    run_literal(1'b1);

    // Backpressure: drop out_ready for 4 cycles after the 2nd handshake.
    base_h = hs_count; base_d = done_pulses; stall = 0;
    start = 1'b1; transpose = 1'b0; out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 60 && ph != P_IDLE; k++) begin
      if (stall == 0 && hs_count - base_h == 2) stall = 1;
      out_ready = !(stall >= 1 && stall <= 4);
      @(negedge clk);
      if (stall >= 1 && stall <= 4) begin
        check("bp_readEN", 32'(mem_readEN), 32'd0);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_data_hold", 32'(out_data), 32'hA002);
        stall++;
      end
      step();
    end
    out_ready = 1'b1;
    check("bp_words", 32'(hs_count - base_h), 32'd6);
    check("bp_done", 32'(done_pulses - base_d), 32'd1);

    // Reset one cycle after the 3rd handshake, then restart from address 0.
    base_h = hs_count;
    start = 1'b1; transpose = 1'b0; out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 20 && hs_count - base_h < 3; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ramEN", 32'(mem_ramEN), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    step();
    base_h = hs_count;
    run_stream(1'b0, 100, 0, -1, 60);
    check("post_rst_words", 32'(hs_count - base_h), 32'd6);

    // Start pulsed during RUN (cycle 3) and during DONE (cycle 9) is ignored.
    base_h = hs_count; base_d = done_pulses;
    for (int c = 0; c <= 14; c++) begin
      start = (c == 0 || c == 3 || c == 9);
      transpose = 1'b0; out_ready = 1'b1;
      step();
    end
    start = 1'b0;
    check("ign_words", 32'(hs_count - base_h), 32'd6);
    check("ign_done", 32'(done_pulses - base_d), 32'd1);
    check("ign_idle", 32'(busy), 32'd0);

    // Randomized runs: random order, backpressure, stray starts, some resets.
    for (int r = 0; r < 16; r++) begin
      run_stream(1'($urandom_range(1)), 40 + $urandom_range(60), 10,
                 ($urandom_range(3) == 0) ? 2 + $urandom_range(15) : -1, 300);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
